// File: rtl/mem_bus_engine.sv
// MAR/MDR memory bus engine: latches address/data from the internal bus and runs
// req/ack memory cycles with timeout. Optional MEM_AUTOINC_EN: MAR increments after each completed access.
module mem_bus_engine #(
    parameter int CPU_W   = 32,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TMO_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              marce,
    input  logic              mdrput,
    input  logic              mdrget,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [CPU_W-1:0]  int_bus_in,
    output logic [CPU_W-1:0]  int_bus_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int CNT_W = (TMO_CYC < 1) ? 1 : $clog2(TMO_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE,
        S_FAIL
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] mar_reg, mar_next;
    logic [DATA_W-1:0] mdr_reg, mdr_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              we_reg, we_next;
    logic              ill_reg, ill_next;

    // Upper internal-bus bits beyond ADDR_W/DATA_W are intentionally dropped.
    logic unused_bus;
    assign unused_bus = ^int_bus_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            mar_reg   <= '0;
            mdr_reg   <= '0;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            ill_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            mar_reg   <= mar_next;
            mdr_reg   <= mdr_next;
            cnt_reg   <= cnt_next;
            we_reg    <= we_next;
            ill_reg   <= ill_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mar_next   = mar_reg;
        mdr_next   = mdr_reg;
        cnt_next   = cnt_reg;
        we_next    = we_reg;
        ill_next   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (marce)
                    mar_next = int_bus_in[ADDR_W-1:0];
                if (mdrput)
                    mdr_next = int_bus_in[DATA_W-1:0];
                // Simultaneous read and write is rejected without touching memory.
                if (rd_req && wr_req) begin
                    ill_next = 1'b1;
                end else if (rd_req || wr_req) begin
                    state_next = S_ACCESS;
                    cnt_next   = '0;
                    we_next    = wr_req;
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    state_next = S_DONE;
                    if (!we_reg)
                        mdr_next = mem_rdata;
                end else if (cnt_reg == CNT_W'(TMO_CYC)) begin
                    state_next = S_FAIL;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
`ifdef MEM_AUTOINC_EN
                mar_next = mar_reg + 1'b1;
`else
                mar_next = mar_reg;
`endif
            end
            S_FAIL: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_reg == S_ACCESS);
    assign mem_req   = (state_reg == S_ACCESS);
    assign mem_we    = (state_reg == S_ACCESS) && we_reg;
    assign done      = (state_reg == S_DONE);
    assign err       = (state_reg == S_FAIL) || ill_reg;
    assign mem_addr  = mar_reg;
    assign mem_wdata = mdr_reg;

    // Zero-extended MDR onto the internal bus, gated by mdrget.
    for (genvar gi = 0; gi < CPU_W; gi++) begin : g_bus_out
        if (gi < DATA_W) begin : g_data
            assign int_bus_out[gi] = mdrget & mdr_reg[gi];
        end else begin : g_zero
            assign int_bus_out[gi] = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_bus_engine.sv
// Directed + randomized bench for mem_bus_engine; the bench plays the memory and
// tracks expected MAR/MDR and per-access outcome from the bus protocol rules.
module tb_mem_bus_engine;

    localparam int CPU_W   = 32;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int TMO_CYC = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              marce, mdrput, mdrget, rd_req, wr_req;
    logic [CPU_W-1:0]  int_bus_in;
    logic [CPU_W-1:0]  int_bus_out;
    logic              busy, done, err, mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    int errors = 0;
    int checks = 0;
    logic [ADDR_W-1:0] exp_mar;
    logic [DATA_W-1:0] exp_mdr;

    mem_bus_engine #(
        .CPU_W(CPU_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .marce(marce), .mdrput(mdrput), .mdrget(mdrget),
        .rd_req(rd_req), .wr_req(wr_req), .int_bus_in(int_bus_in), .int_bus_out(int_bus_out),
        .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bus();
        mdrget = 1'b1;
        #1;
        check("mdrget_bus", int_bus_out, {16'h0, exp_mdr});
        mdrget = 1'b0;
        #1;
        check("bus_idle_zero", int_bus_out, 32'h0);
    endtask

    task automatic load_mar(input logic [31:0] v);
        marce = 1'b1; int_bus_in = v;
        tick();
        marce = 1'b0; int_bus_in = $urandom;
        exp_mar = v[15:0];
        check("mar_load", mem_addr, exp_mar);
    endtask

    task automatic load_mdr(input logic [31:0] v);
        mdrput = 1'b1; int_bus_in = v;
        tick();
        mdrput = 1'b0; int_bus_in = $urandom;
        exp_mdr = v[15:0];
        check("mdr_load", mem_wdata, exp_mdr);
    endtask

    // lat < 0 means the memory never acknowledges.
    task automatic run_access(input bit is_wr, input int lat, input logic [15:0] rdata, input bit poke);
        int cyc;
        if (is_wr) wr_req = 1'b1; else rd_req = 1'b1;
        tick();
        rd_req = 1'b0; wr_req = 1'b0;
        check("acc_busy", busy, 1);
        check("acc_req", mem_req, 1);
        check("acc_we", mem_we, is_wr);
        check("acc_addr", mem_addr, exp_mar);
        if (is_wr) check("acc_wdata", mem_wdata, exp_mdr);
        if (poke) begin
            wr_req = 1'b1; marce = 1'b1; mdrput = 1'b1; int_bus_in = $urandom;
        end
        cyc = 1;
        for (int k = 0; k < 40 && mem_req; k++) begin
            mem_ack   = (k == lat);
            mem_rdata = (k == lat) ? rdata : 16'($urandom);
            tick();
            mem_ack = 1'b0; wr_req = 1'b0; marce = 1'b0; mdrput = 1'b0;
            if (mem_req) cyc++;
        end
        check("req_bounded", mem_req, 0);
        if (lat >= 0) begin
            check("req_cycles", cyc, lat + 1);
            check("done_pulse", done, 1);
            check("no_err", err, 0);
            if (!is_wr) exp_mdr = rdata;
        end else begin
            check("tmo_window", (cyc >= TMO_CYC && cyc <= TMO_CYC + 1), 1);
            check("tmo_err", err, 1);
            check("tmo_no_done", done, 0);
        end
        check("end_busy", busy, 0);
        check("end_we", mem_we, 0);
        check_bus();
        tick();
        check("done_clear", done, 0);
        check("err_clear", err, 0);
`ifdef MEM_AUTOINC_EN
        if (lat >= 0) exp_mar = exp_mar + 16'd1;
`endif
        check("mar_after", mem_addr, exp_mar);
        check("mdr_after", mem_wdata, exp_mdr);
    endtask

    initial begin
        rst_n = 1'b0; marce = 0; mdrput = 0; mdrget = 0; rd_req = 0; wr_req = 0;
        int_bus_in = '0; mem_rdata = '0; mem_ack = 0;
        exp_mar = '0; exp_mdr = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_req", mem_req, 0);
        check("rst_done_err", {done, err, mem_we}, 0);
        check("rst_mar", mem_addr, 0);
        check("rst_mdr", mem_wdata, 0);
        rst_n = 1'b1;
        tick();

        // 1: write with ack after 2 cycles
        load_mar(32'h0000_1234);
        load_mdr(32'h0000_BEEF);
        run_access(1'b1, 2, 16'h0, 1'b0);

        // 2: minimum-latency read
        load_mar(32'h0000_0010);
        run_access(1'b0, 0, 16'hA5A5, 1'b0);

        // 3: timeout, then a late ack in IDLE is ignored
        run_access(1'b0, -1, 16'h0, 1'b0);
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        tick();
        mem_ack = 1'b0;
        check("late_ack_busy", busy, 0);
        check("late_ack_done", done, 0);
        check("late_ack_mdr", mem_wdata, exp_mdr);

        // 4: illegal simultaneous request, then stray requests during ACCESS
        rd_req = 1'b1; wr_req = 1'b1;
        tick();
        rd_req = 1'b0; wr_req = 1'b0;
        check("ill_err", err, 1);
        check("ill_req", mem_req, 0);
        tick();
        check("ill_err_clear", err, 0);
        check("ill_req_still", mem_req, 0);
        run_access(1'b0, 3, 16'h5A5A, 1'b1);

        // both loads in one IDLE cycle
        marce = 1'b1; mdrput = 1'b1; int_bus_in = 32'hCAFE_3C3C;
        tick();
        marce = 1'b0; mdrput = 1'b0;
        exp_mar = 16'h3C3C; exp_mdr = 16'h3C3C;
        check("dual_mar", mem_addr, exp_mar);
        check("dual_mdr", mem_wdata, exp_mdr);

        // 5: reset during ACCESS
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        check("pre_rst_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        check("arst_req", mem_req, 0);
        check("arst_flags", {busy, done, err, mem_we}, 0);
        check("arst_mar", mem_addr, 0);
        check("arst_mdr", mem_wdata, 0);
        exp_mar = '0; exp_mdr = '0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_done", {done, err, busy}, 0);
        check_bus();

        // 6: MAR wrap behaviour
        load_mar(32'hAAAA_FFFF);
        run_access(1'b0, 1, 16'h0F0F, 1'b0);
        run_access(1'b0, 0, 16'hF0F0, 1'b0);

        // randomized traffic
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 1) == 1) load_mar($urandom);
            if ($urandom_range(0, 1) == 1) load_mdr($urandom);
            run_access(1'($urandom_range(0, 1)),
                       ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TMO_CYC - 1)),
                       16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
